// File: rtl/register_dump_unit_pkg.sv
// Shared constants and types for the register dump unit: widths, byte
// count per register word and the FSM state encoding.
package register_dump_unit_pkg;

    localparam int TAM_DATA       = 32;
    localparam int TAM_DIREC_REG  = 5;
    localparam int CANT_REGISTROS = 32;
    localparam int TAM_BYTE       = 8;

    localparam int BYTES_POR_DATO = TAM_DATA / TAM_BYTE;
    localparam int TAM_CONT_BYTE  = $clog2(BYTES_POR_DATO);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        SEND = 3'd2,
        WAIT = 3'd3,
        NEXT = 3'd4,
        DONE = 3'd5
    } state_t;

    typedef logic [TAM_DATA-1:0]      dato_t;
    typedef logic [TAM_DIREC_REG-1:0] direc_t;
    typedef logic [TAM_BYTE-1:0]      byte_t;
    typedef logic [TAM_CONT_BYTE-1:0] cont_byte_t;

endpackage

// File: rtl/register_dump_unit_if.sv
// Bus bundle between the dump unit, the register-file debug read port and
// the debug UART transmitter.
//
// Handshake: the master drives o_tx_dato and pulses o_tx_start for one
// cycle; the byte is owned by the transmitter until it answers with a
// one-cycle i_tx_done pulse. The master keeps o_tx_dato stable over that
// whole window and never raises o_tx_start again before i_tx_done.
// The debug read port is purely combinational: i_dato_a_debug reflects
// o_direc_de_lectura_de_debug in the same cycle.
interface register_dump_unit_if;
    import register_dump_unit_pkg::*;

    direc_t o_direc_de_lectura_de_debug;
    dato_t  i_dato_a_debug;
    byte_t  o_tx_dato;
    logic   o_tx_start;
    logic   i_tx_done;

    modport master (
        output o_direc_de_lectura_de_debug,
        input  i_dato_a_debug,
        output o_tx_dato,
        output o_tx_start,
        input  i_tx_done
    );

    modport slave (
        input  o_direc_de_lectura_de_debug,
        output i_dato_a_debug,
        input  o_tx_dato,
        input  o_tx_start,
        output i_tx_done
    );

endinterface

// File: rtl/register_dump_unit_mux.sv
// Generic word-to-slice multiplexer: picks slice 'enable' of BUS_SIZE bits
// out of a packed word of 2**BITS_ENABLES slices (slice 0 = LSBs).
module register_dump_unit_mux #(
    parameter int BITS_ENABLES = 2,
    parameter int BUS_SIZE     = 8
) (
    input  logic [BITS_ENABLES-1:0]                enable,
    input  logic [(2**BITS_ENABLES)*BUS_SIZE-1:0] data,
    output logic [BUS_SIZE-1:0]                    selected
);

    // Pure combinational slice selection
    always_comb begin
        selected = data[enable*BUS_SIZE +: BUS_SIZE];
    end

endmodule

// File: rtl/register_dump_unit.sv
// Walks the register file debug port, captures each register and streams
// it LSB byte first to the debug UART transmitter.
module register_dump_unit
    import register_dump_unit_pkg::*;
(
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_start,
    register_dump_unit_if.master        bus,
    output logic                        o_busy,
    output logic                        o_done,
    output state_t                      o_state
);

    localparam direc_t     ULTIMA_DIREC = direc_t'(CANT_REGISTROS - 1);
    localparam cont_byte_t ULTIMO_BYTE  = cont_byte_t'(BYTES_POR_DATO - 1);

    state_t     state;
    state_t     state_next;
    direc_t     direc;
    cont_byte_t cont_byte;
    dato_t      captura;

    // State register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state <= IDLE;
        else         state <= state_next;
    end

    // Next-state logic; i_tx_done only matters in WAIT, i_start only in IDLE
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (i_start) state_next = LOAD;
            LOAD: state_next = SEND;
            SEND: state_next = WAIT;
            WAIT: if (bus.i_tx_done) state_next = (cont_byte == ULTIMO_BYTE) ? NEXT : SEND;
            NEXT: state_next = (direc == ULTIMA_DIREC) ? DONE : LOAD;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Address, byte counter and capture register; the register value is
    // sampled only in LOAD so later register-file writes do not tear a word
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            direc     <= '0;
            cont_byte <= '0;
            captura   <= '0;
        end else begin
            unique case (state)
                IDLE: if (i_start) direc <= '0;
                LOAD: begin
                    captura   <= bus.i_dato_a_debug;
                    cont_byte <= '0;
                end
                WAIT: if (bus.i_tx_done && (cont_byte != ULTIMO_BYTE)) cont_byte <= cont_byte + 1'b1;
                NEXT: if (direc != ULTIMA_DIREC) direc <= direc + 1'b1;
                DONE: direc <= '0;
                default: ;
            endcase
        end
    end

    // Moore outputs decoded from the current state
    always_comb begin
        bus.o_tx_start = (state == SEND);
        o_busy         = (state != IDLE) && (state != DONE);
        o_done         = (state == DONE);
        o_state        = state;
    end

    assign bus.o_direc_de_lectura_de_debug = direc;

    register_dump_unit_mux #(
        .BITS_ENABLES (TAM_CONT_BYTE),
        .BUS_SIZE     (TAM_BYTE)
    ) u_byte_mux (
        .enable   (cont_byte),
        .data     (captura),
        .selected (bus.o_tx_dato)
    );

endmodule

// File: tb/tb_register_dump_unit.sv
// Directed bench for register_dump_unit with a register-file model, a UART
// TX model with programmable done latency and an expected-byte queue.
module tb_register_dump_unit;
    import register_dump_unit_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic        tx_done_model;
    logic        tx_done_stray;
    logic        busy;
    logic        done;
    state_t      dbg_state;
    logic [31:0] regs [32];
    logic [7:0]  exp_q [$];

    int     total;
    int     bad;
    int     start_cnt;
    int     done_cnt;
    int     tx_delay;
    bit     chk_cyc;
    longint t_edge;

    register_dump_unit_if bus ();

    assign bus.i_dato_a_debug = regs[bus.o_direc_de_lectura_de_debug];
    assign bus.i_tx_done      = tx_done_model | tx_done_stray;

    register_dump_unit dut (
        .i_clk   (clk),
        .i_reset (rst),
        .i_start (start),
        .bus     (bus.master),
        .o_busy  (busy),
        .o_done  (done),
        .o_state (dbg_state)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        total++;
        assert (obs === req) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    // UART TX model: answers each o_tx_start after tx_delay cycles and
    // checks that the presented byte does not move while it waits
    initial begin : tx_model
        int         left;
        logic [7:0] held;
        bit         pending;
        pending = 1'b0;
        left    = 0;
        held    = '0;
        forever begin
            @(negedge clk);
            tx_done_model = 1'b0;
            if (rst) begin
                pending = 1'b0;
            end else if (pending) begin
                check("tx_dato_held_in_wait", 32'(bus.o_tx_dato), 32'(held));
                if (left <= 1) begin
                    tx_done_model = 1'b1;
                    pending       = 1'b0;
                end else begin
                    left--;
                end
            end else if (bus.o_tx_start) begin
                held    = bus.o_tx_dato;
                pending = 1'b1;
                left    = tx_delay;
            end
        end
    end

    // Scoreboard monitor: pops one expected byte per o_tx_start, times o_done
    initial begin : monitor
        logic [7:0] e;
        longint     cyc;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.o_tx_start) begin
                    start_cnt++;
                    check("tx_start_expected", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check($sformatf("tx_byte_%0d", start_cnt - 1), 32'(bus.o_tx_dato), 32'(e));
                    end
                end
                if (done) begin
                    done_cnt++;
                    cyc = (($time - t_edge - 5) / 10) + 1;
                    if (chk_cyc) check("done_cycle", 32'(cyc), 32'd321);
                end
            end
        end
    end

    task automatic push_expected(input bit ovr, input logic [31:0] ovr_val);
        logic [31:0] v;
        for (int r = 0; r < 32; r++) begin
            v = (ovr && r == 5) ? ovr_val : regs[r];
            for (int b = 0; b < 4; b++) exp_q.push_back(v[8*b +: 8]);
        end
    endtask

    // Leaves the caller at the negedge of cycle 1 (the LOAD cycle)
    task automatic begin_dump(input bit ovr, input logic [31:0] ovr_val, input bit cyc_chk);
        start_cnt = 0;
        done_cnt  = 0;
        chk_cyc   = cyc_chk;
        push_expected(ovr, ovr_val);
        @(negedge clk);
        start  = 1'b1;
        t_edge = $time + 5;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done_cnt == 0 && n < 10000) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
        check({tag, "_start_count"}, 32'(start_cnt), 32'd128);
        check({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_busy_idle"}, 32'(busy), 32'd0);
        check({tag, "_state_idle"}, 32'(dbg_state), 32'(IDLE));
        exp_q.delete();
    endtask

    initial begin : main
        int n;
        total         = 0;
        bad           = 0;
        start_cnt     = 0;
        done_cnt      = 0;
        tx_delay      = 1;
        chk_cyc       = 1'b0;
        t_edge        = 0;
        rst           = 1'b1;
        start         = 1'b0;
        tx_done_stray = 1'b0;
        tx_done_model = 1'b0;
        for (int r = 0; r < 32; r++) regs[r] = 32'h11223300 + 32'(r);

        // reset state
        repeat (3) @(negedge clk);
        check("rst_direc", 32'(bus.o_direc_de_lectura_de_debug), 32'd0);
        check("rst_tx_dato", 32'(bus.o_tx_dato), 32'd0);
        check("rst_tx_start", 32'(bus.o_tx_start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        rst = 1'b0;

        // stray i_tx_done in IDLE does nothing
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tx_done_stray = 1'b1;
            check("idle_stray_busy", 32'(busy), 32'd0);
            check("idle_stray_tx_start", 32'(bus.o_tx_start), 32'd0);
        end
        @(negedge clk);
        tx_done_stray = 1'b0;
        check("idle_stray_state", 32'(dbg_state), 32'(IDLE));

        // scenario 1: fast TX, full dump and o_done timing
        tx_delay = 1;
        begin_dump(1'b0, 32'h0, 1'b1);
        wait_done("fast");

        // scenario 2: slow TX, bytes held across long waits
        tx_delay = 50;
        begin_dump(1'b0, 32'h0, 1'b0);
        wait_done("slow");

        // scenario 3: stray i_tx_done in LOAD/SEND/NEXT and i_start while busy
        tx_delay = 1;
        begin_dump(1'b0, 32'h0, 1'b1);
        for (int k = 1; k <= 320; k++) begin
            if (k > 1) @(negedge clk);
            tx_done_stray = (k % 10 == 1) || (k % 10 == 2) || (k % 10 == 0);
            start         = (k % 7 == 3);
        end
        @(negedge clk);
        tx_done_stray = 1'b0;
        start         = 1'b0;
        wait_done("stray");

        // scenario 4: reset during register 7, byte 2, then restart
        tx_delay = 1;
        begin_dump(1'b0, 32'h0, 1'b1);
        n = 0;
        while (start_cnt < 31 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        check("reach_reg7_byte2", 32'(start_cnt), 32'd31);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_direc", 32'(bus.o_direc_de_lectura_de_debug), 32'd0);
        check("async_rst_tx_dato", 32'(bus.o_tx_dato), 32'd0);
        check("async_rst_tx_start", 32'(bus.o_tx_start), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        check("async_rst_state", 32'(dbg_state), 32'(IDLE));
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_tx_start", 32'(bus.o_tx_start), 32'd0);
        begin_dump(1'b0, 32'h0, 1'b1);
        wait_done("restart");

        // scenario 5: register 5 rewritten while register 3 is being sent
        tx_delay = 1;
        begin_dump(1'b1, 32'hDEADBEEF, 1'b1);
        n = 0;
        while (start_cnt < 13 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        check("reach_reg3", 32'(start_cnt), 32'd13);
        regs[5] = 32'hDEADBEEF;
        wait_done("write");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/register_dump_unit.md
Name: register_dump_unit

Overview:
- Debug-side reader of the register file's debug read port.
- On a start pulse, walks register addresses 0..CANT_REGISTROS-1 and captures each 32-bit value. It sends each value as 4 bytes, least-significant byte first, to the UART transmitter using a start/done byte handshake.
- Sits between the instruction-decode debug port and the debug UART TX; it is the consumer of that port.

Parameters:
- TAM_DATA, 32, register data width; must be a multiple of TAM_BYTE.
- TAM_DIREC_REG, 5, register address width.
- CANT_REGISTROS, 32, number of registers dumped; must be ≤ 2**TAM_DIREC_REG.
- TAM_BYTE, 8, UART byte width.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_start  in  1  dump request, sampled in IDLE only.
- o_direc_de_lectura_de_debug  out  TAM_DIREC_REG  debug read address to the register file.
- i_dato_a_debug  in  TAM_DATA  combinational read data for o_direc_de_lectura_de_debug.
- o_tx_dato  out  TAM_BYTE  byte presented to the UART TX.
- o_tx_start  out  1  one-cycle pulse: UART TX accepts o_tx_dato.
- i_tx_done  in  1  one-cycle pulse from UART TX: current byte finished.
- o_busy  out  1  high from the cycle after i_start is accepted until DONE.
- o_done  out  1  one-cycle pulse after the last byte of the last register.

Behaviour:
- Reset values: state IDLE; o_direc_de_lectura_de_debug=0; o_tx_dato=0; o_tx_start=0; o_busy=0; o_done=0; byte counter=0; capture register=0.
- Reset mid-operation returns all state and outputs to the reset values immediately. No further o_tx_start is issued, and a UART byte already in flight is abandoned.
- IDLE: if i_start=1, go to LOAD, set address=0 and o_busy=1. Otherwise stay in IDLE.
- LOAD: the address has been stable for at least one cycle. Capture i_dato_a_debug into the capture register, clear the byte counter, go to SEND.
- SEND: o_tx_start=1 for exactly this cycle, then go to WAIT.
- WAIT: o_tx_start=0. On i_tx_done=1:
  - if byte counter = TAM_DATA/TAM_BYTE-1, go to NEXT;
  - otherwise increment the byte counter and go to SEND.
- NEXT: if address = CANT_REGISTROS-1, go to DONE. Otherwise increment the address and go to LOAD. The address never wraps past CANT_REGISTROS-1.
- DONE: o_done=1 for one cycle, o_busy=0, then go to IDLE with the address reset to 0.
- o_tx_dato is always capture[8*k+7 : 8*k], where k is the byte counter. It is stable from SEND through the end of WAIT.
- Ignored inputs:
  - i_start while o_busy=1 is ignored; no restart or queueing.
  - i_tx_done outside WAIT is ignored.
  - i_tx_done in the same cycle as SEND is ignored.
  - i_start asserted in the DONE cycle is ignored; it is accepted in IDLE on the next cycle.
- Timing: when i_tx_done arrives in the first WAIT cycle, each byte takes 2 cycles and each register takes 10 cycles (LOAD + 4×2 + NEXT). o_done is high in cycle 321 after the edge that samples i_start.
- WAIT has no timeout; the block waits indefinitely for i_tx_done.
- Register-file writes during a dump are allowed. Each value is sampled in its LOAD cycle only.

Decomposition:
- Shared debug package holds:
  - state encoding: IDLE, LOAD, SEND, WAIT, NEXT, DONE (3 bits);
  - BYTES_POR_DATO = TAM_DATA/TAM_BYTE;
  - byte counter width = clog2(BYTES_POR_DATO).
- Byte selection reuses the existing mux block (BITS_ENABLES=2, BUS_SIZE=TAM_BYTE) as the one sub-module. The FSM and counters stay in register_dump_unit.

Test Plan:
- Reg file preloaded with reg[n]=32'h11223300+n; pulse i_start; TX model returns i_tx_done 1 cycle after each o_tx_start:
  - expect exactly 128 o_tx_start pulses;
  - bytes per register in order 00+n, 33, 22, 11;
  - one o_done at cycle 321.
- TX model delays i_tx_done by 50 cycles:
  - o_tx_dato is held constant throughout each WAIT;
  - no extra o_tx_start pulses;
  - byte order unchanged.
- Stray i_tx_done pulses in IDLE and in LOAD, SEND and NEXT cycles, plus i_start pulses while o_busy=1:
  - byte stream and o_done timing identical to the first scenario.
- Assert i_reset during register 7, byte 2:
  - all outputs return to 0 asynchronously;
  - a new i_start restarts the dump at address 0, byte 0.
- Write reg[5]=32'hDEADBEEF via the write port while register 3 is being sent:
  - register 5 is dumped as EF, BE, AD, DE;
  - registers 0–3 keep their original values.
